uart_rx_os: RTL and testbench

UART_RX_OS -- requirements
Module: uart_rx_os

---
 rtl/uart_rx_os.sv | 192 +++++++++++++++++++
 tb/tb_uart_rx_os.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: 2-flop input synchronizer, 3-sample majority vote per bit,
// optional parity, and a one-word holding register with ack/overrun handshake.
module uart_rx_os #(
   parameter int OVERSAMPLE = 16,
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = 0
) (
   input  logic                 clk_i,
   input  logic                 rstn_i,
   input  logic                 clr_i,
   input  logic                 brg_stb_i,
   input  logic                 rxd_i,
   output logic [DATA_BITS-1:0] data_o,
   output logic                 valid_o,
   input  logic                 ack_i,
   output logic                 frame_err_o,
   output logic                 parity_err_o,
   output logic                 overrun_o,
   output logic                 busy_o
);

   localparam int TW = $clog2(OVERSAMPLE);
   localparam int BW = $clog2(DATA_BITS);

   localparam logic [TW-1:0] TICK_S0   = TW'(OVERSAMPLE/2 - 1);
   localparam logic [TW-1:0] TICK_S1   = TW'(OVERSAMPLE/2);
   localparam logic [TW-1:0] TICK_S2   = TW'(OVERSAMPLE/2 + 1);
   localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
   localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PAR,
      S_STOP
   } state_t;

   state_t                 state_q;
   logic                   sync1_q;
   logic                   sync2_q;
   logic [TW-1:0]          tick_q;
   logic [BW-1:0]          bitcnt_q;
   logic [1:0]             samp_q;
   logic [DATA_BITS-1:0]   shift_q;
   logic                   par_q;
   logic [DATA_BITS-1:0]   data_q;
   logic                   valid_q;
   logic                   ferr_q;
   logic                   perr_q;
   logic                   ovr_q;
   logic                   busy_q;

   logic                   vote;
   logic                   at_vote;
   logic                   tick_wrap;
   logic                   done_d;
   logic                   perr_d;

   // The third sample is the live synchronized line at the vote tick.
   assign vote      = (samp_q[0] & samp_q[1]) | (samp_q[0] & sync2_q) | (samp_q[1] & sync2_q);
   assign at_vote   = (tick_q == TICK_S2);
   assign tick_wrap = (tick_q == TICK_LAST);
   assign done_d    = brg_stb_i && (state_q == S_STOP) && at_vote;

   always_comb begin
      perr_d = 1'b0;
      if (PARITY == 1) begin
         perr_d = ~(^shift_q ^ par_q);
      end else if (PARITY == 2) begin
         perr_d = ^shift_q ^ par_q;
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         sync1_q  <= 1'b1;
         sync2_q  <= 1'b1;
         state_q  <= S_IDLE;
         tick_q   <= '0;
         bitcnt_q <= '0;
         samp_q   <= '0;
         shift_q  <= '0;
         par_q    <= 1'b0;
         data_q   <= '0;
         valid_q  <= 1'b0;
         ferr_q   <= 1'b0;
         perr_q   <= 1'b0;
         ovr_q    <= 1'b0;
         busy_q   <= 1'b0;
      end else if (clr_i) begin
         sync1_q  <= 1'b1;
         sync2_q  <= 1'b1;
         state_q  <= S_IDLE;
         tick_q   <= '0;
         bitcnt_q <= '0;
         samp_q   <= '0;
         shift_q  <= '0;
         par_q    <= 1'b0;
         data_q   <= '0;
         valid_q  <= 1'b0;
         ferr_q   <= 1'b0;
         perr_q   <= 1'b0;
         ovr_q    <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         sync1_q <= rxd_i;
         sync2_q <= sync1_q;
         ovr_q   <= 1'b0;

         if (valid_q && ack_i) begin
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            perr_q  <= 1'b0;
         end

         // A word acked in the completion cycle frees the holder for the new word.
         if (done_d) begin
            if (!valid_q || ack_i) begin
               data_q  <= shift_q;
               valid_q <= 1'b1;
               ferr_q  <= ~vote;
               perr_q  <= perr_d;
            end else begin
               ovr_q <= 1'b1;
            end
         end

         if (brg_stb_i) begin
            if (tick_q == TICK_S0) samp_q[0] <= sync2_q;
            if (tick_q == TICK_S1) samp_q[1] <= sync2_q;
            if (state_q != S_IDLE) tick_q <= tick_wrap ? '0 : tick_q + 1'b1;

            case (state_q)
               S_IDLE: begin
                  if (!sync2_q) begin
                     state_q <= S_START;
                     tick_q  <= '0;
                     busy_q  <= 1'b1;
                  end
               end
               S_START: begin
                  if (at_vote && vote) begin
                     state_q <= S_IDLE;
                     tick_q  <= '0;
                     busy_q  <= 1'b0;
                  end else if (tick_wrap) begin
                     state_q  <= S_DATA;
                     bitcnt_q <= '0;
                  end
               end
               S_DATA: begin
                  if (at_vote) shift_q <= {vote, shift_q[DATA_BITS-1:1]};
                  if (tick_wrap) begin
                     if (bitcnt_q == BIT_LAST) begin
                        state_q  <= (PARITY != 0) ? S_PAR : S_STOP;
                        bitcnt_q <= '0;
                     end else begin
                        bitcnt_q <= bitcnt_q + 1'b1;
                     end
                  end
               end
               S_PAR: begin
                  if (at_vote) par_q <= vote;
                  if (tick_wrap) state_q <= S_STOP;
               end
               S_STOP: begin
                  // Leave early so the next start edge is never missed.
                  if (at_vote) begin
                     state_q <= S_IDLE;
                     tick_q  <= '0;
                     busy_q  <= 1'b0;
                  end
               end
               default: begin
                  state_q <= S_IDLE;
                  tick_q  <= '0;
                  busy_q  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign data_o       = data_q;
   assign valid_o      = valid_q;
   assign frame_err_o  = ferr_q;
   assign parity_err_o = perr_q;
   assign overrun_o    = ovr_q;
   assign busy_o       = busy_q;

endmodule

// File: tb/tb_uart_rx_os.sv
// Bench for uart_rx_os: one receiver without parity and one with even parity, driven
// by bit-level serial frames and checked against values computed from the frame contents.
module tb_uart_rx_os;

   logic       clk  = 1'b0;
   logic       rstn = 1'b0;
   logic       brg  = 1'b0;

   logic       clr0 = 1'b0, rxd0 = 1'b1, ack0 = 1'b0;
   logic [7:0] data0;
   logic       valid0, ferr0, perr0, ovr0, busy0;

   logic       clrP = 1'b0, rxdP = 1'b1, ackP = 1'b0;
   logic [7:0] dataP;
   logic       validP, ferrP, perrP, ovrP, busyP;

   int testsRun    = 0;
   int testsFailed = 0;
   int ovCount0    = 0;
   int ovCountP    = 0;

   uart_rx_os #(.OVERSAMPLE(16), .DATA_BITS(8), .PARITY(0)) dut0 (
      .clk_i(clk), .rstn_i(rstn), .clr_i(clr0), .brg_stb_i(brg), .rxd_i(rxd0),
      .data_o(data0), .valid_o(valid0), .ack_i(ack0), .frame_err_o(ferr0),
      .parity_err_o(perr0), .overrun_o(ovr0), .busy_o(busy0)
   );

   uart_rx_os #(.OVERSAMPLE(16), .DATA_BITS(8), .PARITY(2)) dutP (
      .clk_i(clk), .rstn_i(rstn), .clr_i(clrP), .brg_stb_i(brg), .rxd_i(rxdP),
      .data_o(dataP), .valid_o(validP), .ack_i(ackP), .frame_err_o(ferrP),
      .parity_err_o(perrP), .overrun_o(ovrP), .busy_o(busyP)
   );

   always #5 clk = ~clk;

   // Baud strobe: one clk high out of every four.
   initial begin
      int n;
      n = 0;
      forever begin
         @(negedge clk);
         n++;
         brg = (n % 4 == 0);
      end
   end

   always @(negedge clk) begin
      if (ovr0 === 1'b1) ovCount0++;
      if (ovrP === 1'b1) ovCountP++;
   end

   initial begin
      #5_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic waitStrobe();
      do @(posedge clk); while (brg !== 1'b1);
      #1;
   endtask

   task automatic driveLine(input bit sel, input logic v);
      if (sel) rxdP = v;
      else     rxd0 = v;
   endtask

   task automatic sendBits(input bit sel, input logic [11:0] bits, input int n);
      for (int i = 0; i < n; i++) begin
         driveLine(sel, bits[i]);
         repeat (16) waitStrobe();
      end
      driveLine(sel, 1'b1);
   endtask

   function automatic logic [11:0] frameBits(input logic [7:0] d, input bit usePar,
                                             input bit parBit, input bit stopBit);
      logic [11:0] b;
      b      = '1;
      b[0]   = 1'b0;
      b[8:1] = d;
      if (usePar) begin
         b[9]  = parBit;
         b[10] = stopBit;
      end else begin
         b[9]  = stopBit;
      end
      return b;
   endfunction

   task automatic sendFrame(input bit sel, input logic [7:0] d, input bit usePar,
                            input bit parBit, input bit stopBit);
      waitStrobe();
      sendBits(sel, frameBits(d, usePar, parBit, stopBit), usePar ? 11 : 10);
   endtask

   task automatic doAck(input bit sel);
      @(posedge clk);
      #1;
      if (sel) ackP = 1'b1;
      else     ack0 = 1'b1;
      @(posedge clk);
      #1;
      ackP = 1'b0;
      ack0 = 1'b0;
   endtask

   // Even-parity (mode 2) or odd-parity (mode 1) rule on data plus parity bit.
   function automatic bit modelParErr(input logic [7:0] d, input bit p, input int mode);
      int ones;
      ones = $countones(d) + int'(p);
      if (mode == 1) return (ones % 2) != 1;
      if (mode == 2) return (ones % 2) != 0;
      return 1'b0;
   endfunction

   task automatic test_reset();
      repeat (3) @(posedge clk);
      #1;
      testsRun++;
      if ({data0, valid0, ferr0, perr0, ovr0, busy0} !== 13'h0) begin
         testsFailed++;
         $display("[TB] FAIL reset_dut0: got %h, expected 0", {data0, valid0, ferr0, perr0, ovr0, busy0});
      end
      testsRun++;
      if ({dataP, validP, ferrP, perrP, ovrP, busyP} !== 13'h0) begin
         testsFailed++;
         $display("[TB] FAIL reset_dutP: got %h, expected 0", {dataP, validP, ferrP, perrP, ovrP, busyP});
      end
      rstn = 1'b1;
      repeat (4) waitStrobe();
   endtask

   task automatic test_basic();
      sendFrame(1'b0, 8'h55, 1'b0, 1'b0, 1'b1);
      testsRun++;
      if ({valid0, data0, ferr0, perr0} !== {1'b1, 8'h55, 2'b00}) begin
         testsFailed++;
         $display("[TB] FAIL basic_word: got v=%b d=%h fe=%b pe=%b, expected v=1 d=55 fe=0 pe=0",
                  valid0, data0, ferr0, perr0);
      end
      doAck(1'b0);
      testsRun++;
      if (valid0 !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL basic_ack_valid: got %b, expected 0", valid0);
      end
      testsRun++;
      if (data0 !== 8'h55) begin
         testsFailed++;
         $display("[TB] FAIL basic_data_hold: got %h, expected 55", data0);
      end
   endtask

   task automatic test_false_start();
      waitStrobe();
      rxd0 = 1'b0;
      repeat (3) waitStrobe();
      rxd0 = 1'b1;
      testsRun++;
      if (busy0 !== 1'b1) begin
         testsFailed++;
         $display("[TB] FAIL false_start_busy_high: got %b, expected 1", busy0);
      end
      repeat (15) waitStrobe();
      testsRun++;
      if ({busy0, valid0} !== 2'b00) begin
         testsFailed++;
         $display("[TB] FAIL false_start_idle: got busy=%b valid=%b, expected 0 0", busy0, valid0);
      end
   endtask

   task automatic test_frame_error();
      sendFrame(1'b0, 8'hA3, 1'b0, 1'b0, 1'b0);
      testsRun++;
      if ({valid0, data0, ferr0, perr0} !== {1'b1, 8'hA3, 2'b10}) begin
         testsFailed++;
         $display("[TB] FAIL frame_err_word: got v=%b d=%h fe=%b pe=%b, expected v=1 d=a3 fe=1 pe=0",
                  valid0, data0, ferr0, perr0);
      end
      repeat (24) waitStrobe();
      doAck(1'b0);
      testsRun++;
      if ({valid0, ferr0} !== 2'b00) begin
         testsFailed++;
         $display("[TB] FAIL frame_err_ack: got v=%b fe=%b, expected 0 0", valid0, ferr0);
      end
   endtask

   task automatic test_parity();
      sendFrame(1'b1, 8'h07, 1'b1, 1'b0, 1'b1);
      testsRun++;
      if ({validP, dataP, perrP, ferrP} !== {1'b1, 8'h07, 2'b10}) begin
         testsFailed++;
         $display("[TB] FAIL parity_bad: got v=%b d=%h pe=%b fe=%b, expected v=1 d=07 pe=1 fe=0",
                  validP, dataP, perrP, ferrP);
      end
      doAck(1'b1);
      testsRun++;
      if ({validP, perrP} !== 2'b00) begin
         testsFailed++;
         $display("[TB] FAIL parity_ack: got v=%b pe=%b, expected 0 0", validP, perrP);
      end
      sendFrame(1'b1, 8'h07, 1'b1, 1'b1, 1'b1);
      testsRun++;
      if ({validP, dataP, perrP} !== {1'b1, 8'h07, 1'b0}) begin
         testsFailed++;
         $display("[TB] FAIL parity_good: got v=%b d=%h pe=%b, expected v=1 d=07 pe=0",
                  validP, dataP, perrP);
      end
      doAck(1'b1);
   endtask

   task automatic test_overrun();
      int base;
      base = ovCount0;
      sendFrame(1'b0, 8'h11, 1'b0, 1'b0, 1'b1);
      sendFrame(1'b0, 8'h22, 1'b0, 1'b0, 1'b1);
      testsRun++;
      if ({valid0, data0} !== {1'b1, 8'h11}) begin
         testsFailed++;
         $display("[TB] FAIL overrun_hold: got v=%b d=%h, expected v=1 d=11", valid0, data0);
      end
      testsRun++;
      if (ovCount0 - base !== 1) begin
         testsFailed++;
         $display("[TB] FAIL overrun_pulse: got %0d cycles, expected 1", ovCount0 - base);
      end
      doAck(1'b0);
      sendFrame(1'b0, 8'h11, 1'b0, 1'b0, 1'b1);
      base = ovCount0;
      // Stop-bit vote of a 10-bit frame lands on strobe 155 after the launching strobe.
      fork
         sendFrame(1'b0, 8'h22, 1'b0, 1'b0, 1'b1);
         begin
            waitStrobe();
            repeat (154) waitStrobe();
            repeat (3) @(posedge clk);
            #1;
            ack0 = 1'b1;
            @(posedge clk);
            #1;
            ack0 = 1'b0;
            testsRun++;
            if ({valid0, data0} !== {1'b1, 8'h22}) begin
               testsFailed++;
               $display("[TB] FAIL ack_on_completion: got v=%b d=%h, expected v=1 d=22", valid0, data0);
            end
         end
      join
      testsRun++;
      if (ovCount0 - base !== 0) begin
         testsFailed++;
         $display("[TB] FAIL ack_on_completion_ovr: got %0d cycles, expected 0", ovCount0 - base);
      end
   endtask

   task automatic test_clear();
      int base;
      waitStrobe();
      sendBits(1'b1, frameBits(8'hF0, 1'b1, 1'b0, 1'b1), 4);
      testsRun++;
      if (busyP !== 1'b1) begin
         testsFailed++;
         $display("[TB] FAIL clear_busy_before: got %b, expected 1", busyP);
      end
      @(posedge clk);
      #1;
      clrP = 1'b1;
      @(posedge clk);
      #1;
      clrP = 1'b0;
      testsRun++;
      if ({busyP, validP} !== 2'b00) begin
         testsFailed++;
         $display("[TB] FAIL clear_midframe: got busy=%b valid=%b, expected 0 0", busyP, validP);
      end
      repeat (4) waitStrobe();
      sendFrame(1'b1, 8'h5A, 1'b1, 1'b0, 1'b1);
      base = ovCountP;
      // Parity frame: stop-bit vote on strobe 171; clear and ack arrive with it.
      fork
         sendFrame(1'b1, 8'hC3, 1'b1, 1'b0, 1'b1);
         begin
            waitStrobe();
            repeat (170) waitStrobe();
            repeat (3) @(posedge clk);
            #1;
            clrP = 1'b1;
            ackP = 1'b1;
            @(posedge clk);
            #1;
            clrP = 1'b0;
            ackP = 1'b0;
         end
      join
      testsRun++;
      if ({validP, dataP, perrP, ferrP} !== 11'h0 || ovCountP != base) begin
         testsFailed++;
         $display("[TB] FAIL clear_priority: got v=%b d=%h pe=%b fe=%b ovr=%0d, expected all 0",
                  validP, dataP, perrP, ferrP, ovCountP - base);
      end
      sendFrame(1'b1, 8'h96, 1'b1, 1'b0, 1'b1);
      testsRun++;
      if ({validP, dataP, perrP} !== {1'b1, 8'h96, 1'b0}) begin
         testsFailed++;
         $display("[TB] FAIL clear_recover: got v=%b d=%h pe=%b, expected v=1 d=96 pe=0",
                  validP, dataP, perrP);
      end
      doAck(1'b1);
   endtask

   task automatic test_reset_midframe();
      waitStrobe();
      sendBits(1'b0, frameBits(8'h3C, 1'b0, 1'b0, 1'b1), 6);
      rstn = 1'b0;
      #1;
      testsRun++;
      if ({data0, valid0, ferr0, perr0, ovr0, busy0} !== 13'h0) begin
         testsFailed++;
         $display("[TB] FAIL reset_midframe: got %h, expected 0", {data0, valid0, ferr0, perr0, ovr0, busy0});
      end
      repeat (2) @(posedge clk);
      #1;
      rstn = 1'b1;
      repeat (4) waitStrobe();
      sendFrame(1'b0, 8'h3C, 1'b0, 1'b0, 1'b1);
      testsRun++;
      if ({valid0, data0, ferr0, perr0} !== {1'b1, 8'h3C, 2'b00}) begin
         testsFailed++;
         $display("[TB] FAIL reset_recover: got v=%b d=%h fe=%b pe=%b, expected v=1 d=3c fe=0 pe=0",
                  valid0, data0, ferr0, perr0);
      end
      doAck(1'b0);
   endtask

   task automatic test_random();
      for (int k = 0; k < 8; k++) begin
         bit         sel, stopBit, parBit, expFe, expPe;
         logic [7:0] d, gotD;
         logic       gotV, gotFe, gotPe;
         int         base;
         sel     = bit'($urandom_range(0, 1));
         d       = 8'($urandom);
         stopBit = ($urandom_range(0, 3) != 0);
         parBit  = (^d) ^ ($urandom_range(0, 2) == 0);
         base    = sel ? ovCountP : ovCount0;
         sendFrame(sel, d, sel, parBit, stopBit);
         expFe = !stopBit;
         expPe = sel ? modelParErr(d, parBit, 2) : 1'b0;
         gotD  = sel ? dataP : data0;
         gotV  = sel ? validP : valid0;
         gotFe = sel ? ferrP : ferr0;
         gotPe = sel ? perrP : perr0;
         testsRun++;
         if ({gotV, gotD, gotFe, gotPe} !== {1'b1, d, expFe, expPe}) begin
            testsFailed++;
            $display("[TB] FAIL random_%0d: got v=%b d=%h fe=%b pe=%b, expected v=1 d=%h fe=%b pe=%b",
                     k, gotV, gotD, gotFe, gotPe, d, expFe, expPe);
         end
         repeat (24) waitStrobe();
         doAck(sel);
         testsRun++;
         if ((sel ? validP : valid0) !== 1'b0 || (sel ? ovCountP : ovCount0) != base) begin
            testsFailed++;
            $display("[TB] FAIL random_ack_%0d: got v=%b ovr=%0d, expected v=0 ovr=0",
                     k, sel ? validP : valid0, (sel ? ovCountP : ovCount0) - base);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_false_start();
      test_frame_error();
      test_parity();
      test_overrun();
      test_clear();
      test_reset_midframe();
      test_random();
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
